// File: rtl/sext_arbiter.sv
// Two-requester arbiter sharing one 17-to-32 sign-extension path.
// The result sits in a single-entry output register with a valid/ready handshake.
module sext_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [16:0]      req0_imm,
    output logic             req0_ack,
    input  logic             req1_valid,
    input  logic [16:0]      req1_imm,
    output logic             req1_ack,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic             res_tag,
    input  logic             res_ready,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              can_accept;
    logic              both_valid;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [16:0]       sel_imm;
    logic              sel_tag;

    function automatic logic [31:0] sext17(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Acks are combinational but forced low while reset is high.
    always_comb begin
        can_accept = ~reset & ((state == EMPTY) | res_ready);
        both_valid = req0_valid & req1_valid;
        grant0     = can_accept & req0_valid & (~req1_valid | last_grant);
        grant1     = can_accept & req1_valid & (~req0_valid | ~last_grant);
        accept     = grant0 | grant1;
        sel_imm    = grant1 ? req1_imm : req0_imm;
        sel_tag    = grant1;
    end

    assign req0_ack = grant0;
    assign req1_ack = grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_tag      <= 1'b0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            if (both_valid && can_accept) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end
            if (accept) begin
                last_grant <= sel_tag;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        res_valid <= 1'b1;
                        res_data  <= sext17(sel_imm);
                        res_tag   <= sel_tag;
                    end
                end
                FULL: begin
                    if (accept) begin
                        res_data  <= sext17(sel_imm);
                        res_tag   <= sel_tag;
                    end else if (res_ready) begin
                        state     <= EMPTY;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sext_arbiter.sv
// Self-checking bench for sext_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_sext_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid;
    logic [16:0] req0_imm;
    logic        req1_valid;
    logic [16:0] req1_imm;
    logic        res_ready;

    logic        req0_ack, req1_ack, res_valid, res_tag;
    logic [31:0] res_data;
    logic [15:0] conflict_cnt;

    logic        s_ack0, s_ack1, s_valid, s_tag;
    logic [31:0] s_data;
    logic [1:0]  s_cnt;

    sext_arbiter #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_ack(req1_ack),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .res_ready(res_ready), .conflict_cnt(conflict_cnt)
    );

    sext_arbiter #(.CNT_W(2)) u_sat (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_ack(s_ack0),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_ack(s_ack1),
        .res_valid(s_valid), .res_data(s_data), .res_tag(s_tag),
        .res_ready(res_ready), .conflict_cnt(s_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Reference model: one result slot, round-robin memory, conflict counts.
    bit          m_full;
    logic [31:0] m_data;
    bit          m_tag;
    bit          m_last;
    int          m_cnt;
    int          m_cnt2;
    int          e_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_ext(input logic [16:0] imm);
        int v;
        v = int'(imm);
        if (v >= 65536) v = v - 131072;
        return 32'(v);
    endfunction

    task automatic cycle();
        bit can;
        #1;
        can = !reset && (!m_full || res_ready);
        e_g = -1;
        if (can) begin
            if (req0_valid && req1_valid) e_g = m_last ? 0 : 1;
            else if (req0_valid)          e_g = 0;
            else if (req1_valid)          e_g = 1;
        end
        check("ack0", 32'(req0_ack), 32'(e_g == 0));
        check("ack1", 32'(req1_ack), 32'(e_g == 1));
        check("sat_ack0", 32'(s_ack0), 32'(e_g == 0));
        check("res_valid", 32'(res_valid), 32'(m_full));
        check("res_data", res_data, m_data);
        check("res_tag", 32'(res_tag), 32'(m_tag));
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        check("sat_cnt", 32'(s_cnt), 32'(m_cnt2));
        @(posedge clock);
        if (reset) begin
            m_full = 0; m_data = '0; m_tag = 0; m_last = 1; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (can && req0_valid && req1_valid) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (e_g >= 0) begin
                m_full = 1;
                m_data = ref_ext(e_g == 1 ? req1_imm : req0_imm);
                m_tag  = (e_g == 1);
                m_last = (e_g == 1);
            end else if (res_ready) begin
                m_full = 0;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [16:0] imms [3];
    logic [31:0] exps [3];
    logic [3:0]  ack_seq;
    logic [3:0]  tag_seq;
    logic [31:0] held;

    initial begin
        m_full = 0; m_data = '0; m_tag = 0; m_last = 1; m_cnt = 0; m_cnt2 = 0;
        reset = 1; req0_valid = 1; req1_valid = 1; req0_imm = 17'h1ABCD; req1_imm = 17'h00123;
        res_ready = 0;
        @(posedge clock); #1;
        m_full = 0; m_data = '0; m_tag = 0; m_last = 1; m_cnt = 0; m_cnt2 = 0;
        cycle();
        cycle();
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);

        // Single request
        reset = 0; req1_valid = 0; req0_valid = 1; req0_imm = 17'h10000; res_ready = 1;
        #1 check("single_ack0", 32'(req0_ack), 32'd1);
        cycle();
        req0_valid = 0;
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_data", res_data, 32'hFFFF0000);
        check("single_tag", 32'(res_tag), 32'd0);

        // Sign cases
        imms[0] = 17'h0FFFF; exps[0] = 32'h0000FFFF;
        imms[1] = 17'h1FFFF; exps[1] = 32'hFFFFFFFF;
        imms[2] = 17'h00000; exps[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_imm = imms[i];
            cycle();
            req0_valid = 0;
            check("sign_data", res_data, exps[i]);
        end

        // Contention after a fresh reset
        reset = 1; cycle(); reset = 0;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            req0_imm = 17'(i * 3); req1_imm = 17'(17'h10000 + i);
            #1 ack_seq[i] = req1_ack;
            check("cont_onehot", 32'(req0_ack ^ req1_ack), 32'd1);
            cycle();
            tag_seq[i] = res_tag;
        end
        check("cont_ack_order", 32'(ack_seq), 32'b1010);
        check("cont_tag_order", 32'(tag_seq), 32'b1010);
        check("cont_cnt4", 32'(conflict_cnt), 32'd4);
        cycle();
        check("cont_cnt5", 32'(conflict_cnt), 32'd5);
        check("sat_cnt3", 32'(s_cnt), 32'd3);

        // Backpressure
        req0_valid = 0; req1_valid = 1; req1_imm = 17'h12345; res_ready = 0;
        held = res_data;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_noack", 32'(req1_ack), 32'd0);
            cycle();
            check("bp_hold", res_data, held);
        end
        res_ready = 1;
        #1 check("bp_ack1", 32'(req1_ack), 32'd1);
        cycle();
        req1_valid = 0;
        check("bp_newdata", res_data, 32'hFFFF2345);
        check("bp_tag", 32'(res_tag), 32'd1);

        // Reset while FULL
        req0_valid = 1; req0_imm = 17'h00042; res_ready = 0;
        cycle();
        req0_valid = 0;
        check("mid_full", 32'(res_valid), 32'd1);
        reset = 1; cycle(); reset = 0;
        check("mid_valid", 32'(res_valid), 32'd0);
        check("mid_cnt", 32'(conflict_cnt), 32'd0);
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1 check("mid_grant0", 32'({req1_ack, req0_ack}), 32'b01);
        cycle();
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Random traffic; requesters hold until acknowledged
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (e_g == 0 || !req0_valid) begin
                req0_valid = $urandom_range(0, 1) == 1;
                req0_imm = 17'($urandom);
            end
            if (e_g == 1 || !req1_valid) begin
                req1_valid = $urandom_range(0, 1) == 1;
                req1_imm = 17'($urandom);
            end
        end
        reset = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
